// File: rtl/multiplexor_2to1_pkg.sv
// Shared constants for the 2:1 word multiplexor slice.
package multiplexor_2to1_pkg;
  localparam int MUX_DEFAULT_WIDTH = 5;
endpackage

// File: rtl/multiplexor_2to1_if.sv
// Data/select bundle between a source (master) and the multiplexor (slave).
interface multiplexor_2to1_if
  import multiplexor_2to1_pkg::*;
#(
  parameter int N = MUX_DEFAULT_WIDTH
);
  logic         sel;
  logic [N-1:0] in0;
  logic [N-1:0] in1;
  logic [N-1:0] mux_out;
  logic [N-1:0] mux_out_q;
  logic         out_vld_q;

  modport master (
    output sel, in0, in1,
    input  mux_out, mux_out_q, out_vld_q
  );

  modport slave (
    input  sel, in0, in1,
    output mux_out, mux_out_q, out_vld_q
  );
endinterface

// File: rtl/multiplexor_2to1_mux_out_reg.sv
// N-bit register with asynchronous clear and a sticky valid flag that
// rises on the first clock edge after reset is released.
module multiplexor_2to1_mux_out_reg
  import multiplexor_2to1_pkg::*;
#(
  parameter int N = MUX_DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o,
  output logic         vld_o
);
  logic [N-1:0] data_q;
  logic [N-1:0] data_d;
  logic         vld_q;
  logic         vld_d;

  assign data_d = d_i;
  assign vld_d  = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q_o   = data_q;
  assign vld_o = vld_q;
endmodule

// File: rtl/multiplexor_2to1.sv
// 2:1 word multiplexor: combinational select plus a registered copy with valid.
module multiplexor_2to1
  import multiplexor_2to1_pkg::*;
#(
  parameter int N = MUX_DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  multiplexor_2to1_if.slave     bus
);
  logic [N-1:0] mux_out_d;

  // A 4-state ternary merges the sources when sel is unknown: agreeing bits
  // pass through, disagreeing bits go X, so neither source is silently chosen.
  assign mux_out_d   = bus.sel ? bus.in1 : bus.in0;
  assign bus.mux_out = mux_out_d;

  multiplexor_2to1_mux_out_reg #(
    .N(N)
  ) u_mux_out_reg (
    .clk   (clk),
    .rst   (rst),
    .d_i   (mux_out_d),
    .q_o   (bus.mux_out_q),
    .vld_o (bus.out_vld_q)
  );
endmodule

// File: tb/tb_multiplexor_2to1.sv
// Self-checking bench for multiplexor_2to1: direct combinational checks plus a
// scoreboard queue for the one-cycle registered path.
module tb_multiplexor_2to1;
  import multiplexor_2to1_pkg::*;

  localparam int N = MUX_DEFAULT_WIDTH;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] model;

  multiplexor_2to1_if #(.N(N)) bus ();

  multiplexor_2to1 #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end else begin
      $display("ok   %s: %b", tag, obs);
    end
  endtask

  task automatic drive(input logic s, input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
    bus.sel = s;
    bus.in0 = a;
    bus.in1 = b;
    model   = s ? b : a;
    #1;
    chk(tag, bus.mux_out, model);
  endtask

  // Expected registered value is queued before the edge and retired after it.
  task automatic tick(input string tag);
    logic [N-1:0] e;
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, bus.mux_out_q, e);
      chk({tag, "_vld"}, {{(N-1){1'b0}}, bus.out_vld_q}, {{(N-1){1'b0}}, 1'b1});
    end
  endtask

  initial begin
    logic         xprobe;
    logic [N-1:0] xexp;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.sel = 1'b0;
    bus.in0 = '0;
    bus.in1 = '0;
    model   = '0;

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    chk("rst_q", bus.mux_out_q, '0);
    chk("rst_vld", {{(N-1){1'b0}}, bus.out_vld_q}, '0);

    drive(1'b0, 5'h15, 5'h00, "sel0_15");
    drive(1'b0, 5'h0A, 5'h00, "sel0_0A");
    drive(1'b1, 5'h00, 5'h15, "sel1_15");
    drive(1'b1, 5'h00, 5'h0A, "sel1_0A");
    chk("held_q", bus.mux_out_q, '0);
    chk("held_vld", {{(N-1){1'b0}}, bus.out_vld_q}, '0);

    // Release and first capture.
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 5'h00, 5'h1F, "rel_comb");
    chk("pre_edge_vld", {{(N-1){1'b0}}, bus.out_vld_q}, '0);
    tick("first_cap");

    // Reset mid-operation: register clears at once, comb path keeps tracking.
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_q", bus.mux_out_q, '0);
    chk("mid_rst_vld", {{(N-1){1'b0}}, bus.out_vld_q}, '0);
    chk("mid_rst_comb", bus.mux_out, 5'h1F);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rel_vld", {{(N-1){1'b0}}, bus.out_vld_q}, '0);

    // Randomised traffic through the registered path.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), N'($urandom), N'($urandom), $sformatf("rnd%0d", i));
      tick($sformatf("rnd%0d_q", i));
    end

    // Unknown select: agreeing sources still resolve.
    @(negedge clk);
    xprobe  = 1'bx;
    bus.in0 = 5'h0A;
    bus.in1 = 5'h0A;
    bus.sel = xprobe;
    #1;
    chk("selx_agree", bus.mux_out, 5'h0A);
    if ($isunknown(xprobe)) begin
      bus.in0 = 5'h15;
      bus.in1 = 5'h0A;
      xexp    = 'x;
      #1;
      chk("selx_differ", bus.mux_out, xexp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end
endmodule
